// File: rtl/logic_processor_pkg.sv
// Shared types and defaults for the bit-serial operand sequencer.
package logic_processor_pkg;

  localparam int DEFAULT_WIDTH = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_HOLD  = 2'd2
  } seq_state_t;

  // Shift counter is sized to hold WIDTH itself so it never wraps mid-operation.
  function automatic int cnt_width(input int width);
    return $clog2(width) + 1;
  endfunction

endpackage

// File: rtl/shift_register.sv
// Operand register: parallel load or serial-in right shift (MSB fed from i_serial_in).
module shift_register
  import logic_processor_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             i_load,
  input  logic             i_shift,
  input  logic [WIDTH-1:0] i_din,
  input  logic             i_serial_in,
  output logic [WIDTH-1:0] o_q
);

  logic [WIDTH-1:0] r_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_q <= '0;
    end else if (i_load) begin
      r_q <= i_din;
    end else if (i_shift) begin
      r_q <= {i_serial_in, r_q[WIDTH-1:1]};
    end
  end

  assign o_q = r_q;

endmodule

// File: rtl/shift_sequencer.sv
// Runs one WIDTH-step bit-serial operation over registers A and B per execute request.
//
//   state | meaning
//   IDLE  | waiting; legal loads accepted while execute is low
//   SHIFT | shifting A and B right once per cycle, WIDTH times
//   HOLD  | operation finished; done pulses on entry, waits for execute to drop
module shift_sequencer
  import logic_processor_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             execute,
  input  logic             load_a,
  input  logic             load_b,
  input  logic [WIDTH-1:0] din,
  input  logic             a_serial_in,
  input  logic             b_serial_in,
  output logic             a_bit,
  output logic             b_bit,
  output logic [WIDTH-1:0] a_reg,
  output logic [WIDTH-1:0] b_reg,
  output logic             busy,
  output logic             done
);

  localparam int CNT_W = cnt_width(WIDTH);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

  seq_state_t       r_state;
  logic [CNT_W-1:0] r_cnt;
  logic             r_busy;
  logic             r_done;

  logic             w_idle_load;
  logic             w_load_a;
  logic             w_load_b;
  logic             w_shift;
  logic [WIDTH-1:0] w_a_q;
  logic [WIDTH-1:0] w_b_q;

  // execute in IDLE wins over any load presented in the same cycle.
  assign w_idle_load = (r_state == ST_IDLE) && !execute;
  assign w_load_a    = w_idle_load && load_a;
  assign w_load_b    = w_idle_load && load_b;
  assign w_shift     = (r_state == ST_SHIFT);

  shift_register #(
    .WIDTH (WIDTH)
  ) u_reg_a (
    .clk         (clk),
    .reset_n     (reset_n),
    .i_load      (w_load_a),
    .i_shift     (w_shift),
    .i_din       (din),
    .i_serial_in (a_serial_in),
    .o_q         (w_a_q)
  );

  shift_register #(
    .WIDTH (WIDTH)
  ) u_reg_b (
    .clk         (clk),
    .reset_n     (reset_n),
    .i_load      (w_load_b),
    .i_shift     (w_shift),
    .i_din       (din),
    .i_serial_in (b_serial_in),
    .o_q         (w_b_q)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (execute) begin
            r_state <= ST_SHIFT;
            r_cnt   <= '0;
            r_busy  <= 1'b1;
          end
        end
        ST_SHIFT: begin
          r_cnt <= r_cnt + 1'b1;
          if (r_cnt == LAST_CNT) begin
            r_state <= ST_HOLD;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
          end
        end
        ST_HOLD: begin
          if (!execute) begin
            r_state <= ST_IDLE;
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign a_reg = w_a_q;
  assign b_reg = w_b_q;
  assign a_bit = w_a_q[0];
  assign b_bit = w_b_q[0];
  assign busy  = r_busy;
  assign done  = r_done;

endmodule
